// File: rtl/alu_control_unit_pkg.sv
// Shared types and constants for the hardwired control sequencer: state encoding,
// opcode values, IR field positions and the opcode-to-instruction-class decode.
package cu_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    CL_NOP, CL_HALT, CL_BIN, CL_MULDIV, CL_UNARY
  } op_class_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RA_HI  = 26;
  localparam int RA_LO  = 23;
  localparam int RB_HI  = 22;
  localparam int RB_LO  = 19;
  localparam int RC_HI  = 18;
  localparam int RC_LO  = 15;

  // Anything not recognised executes as a nop.
  function automatic op_class_t op_class(input logic [4:0] opc);
    case (opc)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA,
      OP_SHL, OP_ROR, OP_ROL:  return CL_BIN;
      OP_MUL, OP_DIV:          return CL_MULDIV;
      OP_NEG, OP_NOT:          return CL_UNARY;
      OP_HALT:                 return CL_HALT;
      default:                 return CL_NOP;
    endcase
  endfunction

endpackage

// File: rtl/alu_control_unit_sel_encode.sv
// Picks Ra/Rb/Rc from the IR and decodes it to one-hot register in/out strobes.
module sel_encode
  import cu_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic [RA_HI:RC_LO]   ir,
  input  logic                 gra,
  input  logic                 grb,
  input  logic                 grc,
  input  logic                 rin,
  input  logic                 rout,
  output logic [NUM_REGS-1:0]  reg_in,
  output logic [NUM_REGS-1:0]  reg_out
);

  logic [3:0]          fld;
  logic [NUM_REGS-1:0] dec;

  always_comb begin
    fld = '0;
    if (gra)      fld = ir[RA_HI:RA_LO];
    else if (grb) fld = ir[RB_HI:RB_LO];
    else if (grc) fld = ir[RC_HI:RC_LO];
    for (int i = 0; i < NUM_REGS; i++)
      dec[i] = (gra | grb | grc) && (fld == 4'(i));
  end

  assign reg_in  = rin  ? dec : '0;
  assign reg_out = rout ? dec : '0;

endmodule

// File: rtl/alu_control_unit.sv
// Moore fetch/execute sequencer driving the DataPath strobes.
// Optional MEM_WAIT_EN adds mem_rdy, which stretches T1 until memory answers.
module alu_control_unit
  import cu_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int OPC_W    = 5
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                start,
  input  logic [31:0]         ir,
`ifdef MEM_WAIT_EN
  input  logic                mem_rdy,
`endif
  output logic                PCout,
  output logic                MARin,
  output logic                IncPC,
  output logic                PCin,
  output logic                Read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                HIin,
  output logic                LOin,
  output logic [4:0]          alu_op,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [NUM_REGS-1:0] reg_out,
  output logic                run,
  output logic                instr_done,
  output logic                halted
);

  state_t     state, state_nxt;
  op_class_t  cls;
  logic [4:0] opc;
  logic       gra, grb, grc, rin, rout;
  logic       t1_go;

  assign opc = 5'(ir[OPC_HI -: OPC_W]);
  assign cls = op_class(opc);

`ifdef MEM_WAIT_EN
  assign t1_go = mem_rdy;
`else
  assign t1_go = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (clear) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_T0;
      S_T0:   state_nxt = S_T1;
      S_T1:   if (t1_go) state_nxt = S_T2;
      S_T2:   case (cls)
                CL_NOP:  state_nxt = S_T0;
                CL_HALT: state_nxt = S_HALT;
                default: state_nxt = S_T3;
              endcase
      S_T3:   state_nxt = S_T4;
      S_T4:   if (cls == CL_UNARY) state_nxt = start ? S_T0 : S_IDLE;
              else                 state_nxt = S_T5;
      S_T5:   if (cls == CL_MULDIV) state_nxt = S_T6;
              else                  state_nxt = start ? S_T0 : S_IDLE;
      S_T6:   state_nxt = start ? S_T0 : S_IDLE;
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin} = '0;
    {Yin, Zin, Zlowout, Zhighout, HIin, LOin}              = '0;
    {gra, grb, grc, rin, rout}                             = '0;
    alu_op     = '0;
    instr_done = 1'b0;
    run        = (state >= S_T0) && (state <= S_T6);
    halted     = (state == S_HALT);
    case (state)
      S_T0: {PCout, MARin, IncPC, Zin} = '1;
      S_T1: {Zlowout, PCin, Read, MDRin} = '1;
      S_T2: begin
        {MDRout, IRin} = '1;
        instr_done = (cls == CL_NOP);
      end
      S_T3: case (cls)
        CL_BIN:    begin grb = 1'b1; rout = 1'b1; Yin = 1'b1; end
        CL_MULDIV: begin gra = 1'b1; rout = 1'b1; Yin = 1'b1; end
        CL_UNARY:  begin grb = 1'b1; rout = 1'b1; Zin = 1'b1; alu_op = opc; end
        default:   ;
      endcase
      S_T4: case (cls)
        CL_BIN:    begin grc = 1'b1; rout = 1'b1; Zin = 1'b1; alu_op = opc; end
        CL_MULDIV: begin grb = 1'b1; rout = 1'b1; Zin = 1'b1; alu_op = opc; end
        CL_UNARY:  begin Zlowout = 1'b1; gra = 1'b1; rin = 1'b1; instr_done = 1'b1; end
        default:   ;
      endcase
      S_T5: case (cls)
        CL_BIN:    begin Zlowout = 1'b1; gra = 1'b1; rin = 1'b1; instr_done = 1'b1; end
        CL_MULDIV: begin Zlowout = 1'b1; LOin = 1'b1; end
        default:   ;
      endcase
      S_T6: if (cls == CL_MULDIV) begin
        Zhighout = 1'b1; HIin = 1'b1; instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  sel_encode #(.NUM_REGS(NUM_REGS)) u_sel (
    .ir      (ir[RA_HI:RC_LO]),
    .gra     (gra),
    .grb     (grb),
    .grc     (grc),
    .rin     (rin),
    .rout    (rout),
    .reg_in  (reg_in),
    .reg_out (reg_out)
  );

endmodule

// File: tb/tb_alu_control_unit.sv
// Scoreboard bench: each driven cycle pushes the expected strobe set, the negedge monitor pops and compares.
module tb_alu_control_unit;

  logic        clock = 1'b0;
  logic        clear, start, mem_rdy;
  logic [31:0] ir;
  logic        PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin;
  logic        Yin, Zin, Zlowout, Zhighout, HIin, LOin, run, instr_done, halted;
  logic [4:0]  alu_op;
  logic [15:0] reg_in, reg_out;

  always #5 clock = ~clock;

  alu_control_unit dut (
    .clock(clock), .clear(clear), .start(start), .ir(ir),
`ifdef MEM_WAIT_EN
    .mem_rdy(mem_rdy),
`endif
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin),
    .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
    .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout),
    .HIin(HIin), .LOin(LOin), .alu_op(alu_op), .reg_in(reg_in),
    .reg_out(reg_out), .run(run), .instr_done(instr_done), .halted(halted)
  );

  localparam logic [16:0] B_PCOUT = 17'h10000, B_MARIN = 17'h08000, B_INCPC = 17'h04000;
  localparam logic [16:0] B_PCIN  = 17'h02000, B_READ  = 17'h01000, B_MDRIN = 17'h00800;
  localparam logic [16:0] B_MDROUT= 17'h00400, B_IRIN  = 17'h00200, B_YIN   = 17'h00100;
  localparam logic [16:0] B_ZIN   = 17'h00080, B_ZLOW  = 17'h00040, B_ZHIGH = 17'h00020;
  localparam logic [16:0] B_HIIN  = 17'h00010, B_LOIN  = 17'h00008, B_RUN   = 17'h00004;
  localparam logic [16:0] B_DONE  = 17'h00002, B_HALT  = 17'h00001;

  localparam logic [16:0] E_T0 = B_PCOUT | B_MARIN | B_INCPC | B_ZIN | B_RUN;
  localparam logic [16:0] E_T1 = B_ZLOW | B_PCIN | B_READ | B_MDRIN | B_RUN;
  localparam logic [16:0] E_T2 = B_MDROUT | B_IRIN | B_RUN;

  typedef struct {
    string       tag;
    logic [53:0] v;
  } exp_t;

  exp_t q[$];
  int   errs = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, act, expv);
    end
  endtask

  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.tag, 64'({PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin, Zin,
                      Zlowout, Zhighout, HIin, LOin, run, instr_done, halted,
                      alu_op, reg_in, reg_out}), 64'(e.v));
    end
  end

  // One clock: expected outputs of the present state, inputs for the next edge.
  task automatic cyc(input logic st, input logic clr, input logic [16:0] s,
                     input logic [4:0] op, input logic [15:0] ri, input logic [15:0] ro,
                     input string tag);
    exp_t e;
    start = st;
    clear = clr;
    e.tag = tag;
    e.v   = {s, op, ri, ro};
    q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic fetch(input logic [31:0] instr, input logic [16:0] t2_extra, input string tag);
    cyc(1'b0, 1'b0, E_T0, 5'd0, 16'h0, 16'h0, {tag, "_t0"});
    cyc(1'b0, 1'b0, E_T1, 5'd0, 16'h0, 16'h0, {tag, "_t1"});
    ir = instr;
    cyc(1'b0, 1'b0, E_T2 | t2_extra, 5'd0, 16'h0, 16'h0, {tag, "_t2"});
  endtask

  function automatic logic [31:0] mk_ir(input logic [4:0] opc, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
    return {opc, ra, rb, rc, 15'd0};
  endfunction

  initial begin
    clear = 1'b1; start = 1'b0; ir = '0; mem_rdy = 1'b1;
    @(posedge clock);
    #1;

    cyc(1'b1, 1'b1, 17'h0, 5'd0, 16'h0, 16'h0, "idle_clear_wins");
    cyc(1'b1, 1'b0, 17'h0, 5'd0, 16'h0, 16'h0, "idle_start");

    // and R4, R5, R7
    fetch(32'h2A2B8000, 17'h0, "and");
    cyc(1'b0, 1'b0, B_YIN | B_RUN, 5'd0, 16'h0, 16'h0020, "and_t3");
    cyc(1'b0, 1'b0, B_ZIN | B_RUN, 5'b00101, 16'h0, 16'h0080, "and_t4");
    cyc(1'b0, 1'b0, B_ZLOW | B_RUN | B_DONE, 5'd0, 16'h0010, 16'h0, "and_t5");
    cyc(1'b0, 1'b0, 17'h0, 5'd0, 16'h0, 16'h0, "idle_after_and");
    cyc(1'b1, 1'b0, 17'h0, 5'd0, 16'h0, 16'h0, "idle_start2");

    // mul R2, R6 then back-to-back into neg R1, R3
    fetch(mk_ir(5'b01110, 4'd2, 4'd6, 4'd0), 17'h0, "mul");
    cyc(1'b0, 1'b0, B_YIN | B_RUN, 5'd0, 16'h0, 16'h0004, "mul_t3");
    cyc(1'b0, 1'b0, B_ZIN | B_RUN, 5'b01110, 16'h0, 16'h0040, "mul_t4");
    cyc(1'b0, 1'b0, B_ZLOW | B_LOIN | B_RUN, 5'd0, 16'h0, 16'h0, "mul_t5");
    cyc(1'b1, 1'b0, B_ZHIGH | B_HIIN | B_RUN | B_DONE, 5'd0, 16'h0, 16'h0, "mul_t6");

    fetch(mk_ir(5'b10000, 4'd1, 4'd3, 4'd0), 17'h0, "neg");
    cyc(1'b0, 1'b0, B_ZIN | B_RUN, 5'b10000, 16'h0, 16'h0008, "neg_t3");
    cyc(1'b1, 1'b0, B_ZLOW | B_RUN | B_DONE, 5'd0, 16'h0002, 16'h0, "neg_t4");

    fetch(mk_ir(5'b11111, 4'd9, 4'd9, 4'd9), B_DONE, "undef");
    fetch(mk_ir(5'b11010, 4'd0, 4'd0, 4'd0), B_DONE, "nop");
    fetch(mk_ir(5'b11011, 4'd0, 4'd0, 4'd0), 17'h0, "halt");
    for (int i = 0; i < 10; i++)
      cyc(1'b1, 1'b0, B_HALT, 5'd0, 16'h0, 16'h0, "halt_hold");
    cyc(1'b0, 1'b1, B_HALT, 5'd0, 16'h0, 16'h0, "halt_clear");
    cyc(1'b1, 1'b0, 17'h0, 5'd0, 16'h0, 16'h0, "idle_after_halt");

    // add R3, R1, R2 aborted by clear in T4
    fetch(mk_ir(5'b00011, 4'd3, 4'd1, 4'd2), 17'h0, "add");
    cyc(1'b0, 1'b0, B_YIN | B_RUN, 5'd0, 16'h0, 16'h0002, "add_t3");
    cyc(1'b1, 1'b1, B_ZIN | B_RUN, 5'b00011, 16'h0, 16'h0004, "add_t4_clear");
    cyc(1'b0, 1'b0, 17'h0, 5'd0, 16'h0, 16'h0, "idle_after_abort");

`ifdef MEM_WAIT_EN
    cyc(1'b1, 1'b0, 17'h0, 5'd0, 16'h0, 16'h0, "mw_idle");
    cyc(1'b0, 1'b0, E_T0, 5'd0, 16'h0, 16'h0, "mw_t0");
    mem_rdy = 1'b0;
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b0, E_T1, 5'd0, 16'h0, 16'h0, "mw_t1_wait");
    mem_rdy = 1'b1;
    cyc(1'b0, 1'b0, E_T1, 5'd0, 16'h0, 16'h0, "mw_t1_go");
    ir = mk_ir(5'b11010, 4'd0, 4'd0, 4'd0);
    cyc(1'b0, 1'b0, E_T2 | B_DONE, 5'd0, 16'h0, 16'h0, "mw_t2");
    cyc(1'b0, 1'b1, E_T0, 5'd0, 16'h0, 16'h0, "mw_t0_clear");
    cyc(1'b0, 1'b0, 17'h0, 5'd0, 16'h0, 16'h0, "mw_idle_end");
`endif

    @(negedge clock);
    #1;
    chk("scoreboard_drain", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
